// File: rtl/vol_button_pkg.sv
// Shared state codes, direction type and sizing helper for the volume button front end.
package vol_button_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t HOLD   = 2'd1;
  localparam state_t REPEAT = 2'd2;
  localparam state_t LOCK   = 2'd3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Bits needed to hold 0..max_value, never less than one bit.
  function automatic int unsigned level_width(input int unsigned max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser and stability counter for one raw push-button.
// rise_o pulses for one cycle, registered alongside the debounced level going high.
module button_debounce
  import vol_button_pkg::*;
#(
  parameter int unsigned debounce_cycles_p = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned count_w = level_width(debounce_cycles_p);

  logic               sync_meta;
  logic               sync;
  logic [count_w-1:0] count;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level, so it tops out at debounce_cycles_p and cannot wrap.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      level_o   <= 1'b0;
      rise_o    <= 1'b0;
      count     <= '0;
    end else begin
      sync_meta <= btn_i;
      sync      <= sync_meta;
      rise_o    <= 1'b0;
      if (sync == level_o) begin
        count <= '0;
      end else if (count == count_w'(debounce_cycles_p)) begin
        level_o <= sync;
        rise_o  <= sync;
        count   <= '0;
      end else begin
        count <= count + count_w'(1);
      end
    end
  end

endmodule

// File: rtl/vol_button_ctrl.sv
// Volume up/down button front end: debounced presses become gated one-cycle pulses.
// Hold-to-repeat is built only when VOL_BUTTON_AUTO_REPEAT_EN is defined.
module vol_button_ctrl
  import vol_button_pkg::*;
#(
  parameter int unsigned debounce_cycles_p = 16,
  parameter int unsigned hold_cycles_p     = 64,
  parameter int unsigned repeat_cycles_p   = 16,
  parameter int unsigned min_level_p       = 0,
  parameter int unsigned max_level_p       = 7,
  parameter int unsigned reset_level_p     = 0
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  btn_up_i,
  input  logic                                  btn_down_i,
  output logic                                  up_o,
  output logic                                  down_o,
  output logic [level_width(max_level_p)-1:0]   level_o
);

  localparam int unsigned level_w   = level_width(max_level_p);
  localparam int unsigned count_top = (hold_cycles_p > repeat_cycles_p) ? hold_cycles_p
                                                                        : repeat_cycles_p;
  localparam int unsigned count_w   = level_width(count_top);
  localparam logic [count_w-1:0] count_sat = '1;

  logic up_level;
  logic up_rise;
  logic down_level;
  logic down_rise;

  button_debounce #(
    .debounce_cycles_p(debounce_cycles_p)
  ) u_up_debounce (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .btn_i  (btn_up_i),
    .level_o(up_level),
    .rise_o (up_rise)
  );

  button_debounce #(
    .debounce_cycles_p(debounce_cycles_p)
  ) u_down_debounce (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .btn_i  (btn_down_i),
    .level_o(down_level),
    .rise_o (down_rise)
  );

  state_t             state;
  state_t             state_next;
  dir_e               dir;
  dir_e               dir_next;
  dir_e               fire_dir;
  logic [count_w-1:0] count;
  logic [count_w-1:0] count_next;
  logic               fire;
  logic               held;
  logic               other;
  logic               hold_expire;
  logic               up_ok;
  logic               down_ok;

`ifdef VOL_BUTTON_AUTO_REPEAT_EN
  logic repeat_expire;
  assign hold_expire   = (count == count_w'(hold_cycles_p - 1));
  assign repeat_expire = (count == count_w'(repeat_cycles_p - 1));
`else
  assign hold_expire   = 1'b0;
`endif

  // A due repeat pulse wins over a same-cycle release or conflict; the
  // release is then picked up on the following cycle.
  always_comb begin
    state_next = state;
    dir_next   = dir;
    count_next = (count == count_sat) ? count : count + count_w'(1);
    fire       = 1'b0;
    fire_dir   = dir;
    held       = (dir == DIR_UP) ? up_level : down_level;
    other      = (dir == DIR_UP) ? down_level : up_level;
    case (state)
      IDLE: begin
        count_next = '0;
        if (up_rise && down_rise) begin
          state_next = LOCK;
        end else if (up_rise || down_rise) begin
          fire       = 1'b1;
          fire_dir   = up_rise ? DIR_UP : DIR_DOWN;
          dir_next   = fire_dir;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (hold_expire) begin
          fire       = 1'b1;
          count_next = '0;
          state_next = REPEAT;
        end else if (!held) begin
          state_next = IDLE;
        end else if (other) begin
          state_next = LOCK;
        end
      end
`ifdef VOL_BUTTON_AUTO_REPEAT_EN
      REPEAT: begin
        if (repeat_expire) begin
          fire       = 1'b1;
          count_next = '0;
        end else if (!held) begin
          state_next = IDLE;
        end else if (other) begin
          state_next = LOCK;
        end
      end
`endif
      LOCK: begin
        count_next = '0;
        if (!up_level && !down_level) begin
          state_next = IDLE;
        end
      end
      default: begin
        count_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign up_ok   = fire && (fire_dir == DIR_UP)   && (level_o < level_w'(max_level_p));
  assign down_ok = fire && (fire_dir == DIR_DOWN) && (level_o > level_w'(min_level_p));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      dir     <= DIR_UP;
      count   <= '0;
      up_o    <= 1'b0;
      down_o  <= 1'b0;
      level_o <= level_w'(reset_level_p);
    end else begin
      state  <= state_next;
      dir    <= dir_next;
      count  <= count_next;
      up_o   <= up_ok;
      down_o <= down_ok;
      if (up_ok) begin
        level_o <= level_o + level_w'(1);
      end else if (down_ok) begin
        level_o <= level_o - level_w'(1);
      end
    end
  end

endmodule
